// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, register-file geometry
// and the register-file initialisation FSM state type.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_init_ctrl.sv
// Register-file initialisation controller: after reset, sweeps every entry
// once with zero writes, then raises ready for good (until the next rst).
// Ports: clk, rst (sync, active-high) in; clr_idx (entry being cleared),
// clr_we (clear write strobe), ready (array initialised) out.
module regfile_init_ctrl
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output logic [REG_ADDR_W-1:0] clr_idx,
    output logic                  clr_we,
    output logic                  ready
);

    localparam logic [REG_ADDR_W-1:0] CLR_LAST = REG_ADDR_W'(NUM_REGS - 1);

    rf_state_e             state_q, state_d;
    logic [REG_ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic                  ready_q, ready_d;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        unique case (state_q)
            CLEAR: begin
                // The edge that clears the last entry ends the sweep;
                // the index never wraps back to 0.
                if (clr_idx_q == CLR_LAST) begin
                    state_d = READY;
                    ready_d = 1'b1;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            READY: begin
                state_d = READY;
                ready_d = 1'b1;
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = '0;
                ready_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    // No array write on an edge where rst is sampled high.
    assign clr_we  = (state_q == CLEAR) && !rst;
    assign clr_idx = clr_idx_q;
    assign ready   = ready_q;

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit RISC-V integer register file, two combinational read ports,
// one write port, x0 hard-wired to zero, self-clearing after reset.
// Ports: clk, rst (sync, active-high), reg_write_en/rd_addr/rd_data (write),
// rs1_addr/rs2_addr -> rs1_data/rs2_data (reads), ready (array initialised).
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// to a read port addressing the register being written.
module regfile
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write_en,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]       rd_data,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  ready
);

    logic [XLEN-1:0]       mem_q [NUM_REGS];
    logic [XLEN-1:0]       mem_d [NUM_REGS];
    logic [REG_ADDR_W-1:0] clr_idx;
    logic                  clr_we;
    logic                  rd_ok;
    logic                  wr_fire;

    regfile_init_ctrl u_init_ctrl (
        .clk     (clk),
        .rst     (rst),
        .clr_idx (clr_idx),
        .clr_we  (clr_we),
        .ready   (ready)
    );

    // Reads and writes are only live in READY and outside reset.
    assign rd_ok   = ready && !rst;
    assign wr_fire = rd_ok && reg_write_en && (rd_addr != '0);

    always_comb begin
        mem_d = mem_q;
        if (clr_we) begin
            mem_d[clr_idx] = '0;
        end else if (wr_fire) begin
            mem_d[rd_addr] = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rs1_data = '0;
        if (rd_ok && (rs1_addr != '0)) begin
            rs1_data = mem_q[rs1_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_fire && (rd_addr == rs1_addr)) begin
                rs1_data = rd_data;
            end
`endif
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rd_ok && (rs2_addr != '0)) begin
            rs2_data = mem_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_fire && (rd_addr == rs2_addr)) begin
                rs2_data = rd_data;
            end
`endif
        end
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL declare `clk  input  1`: single clock; all state updates on its rising edge.
REQ-002 SHALL declare `rst  input  1`: reset, synchronous, active-high.
REQ-003 SHALL declare `reg_write_en  input  1`: write request from the write-enable decoder.
REQ-004 SHALL declare `rd_addr  input  5`: destination register index.
REQ-005 SHALL declare `rd_data  input  32`: write-back data.
REQ-006 SHALL declare `rs1_addr  input  5`: read port 1 index.
REQ-007 SHALL declare `rs2_addr  input  5`: read port 2 index.
REQ-008 SHALL declare `rs1_data  output  32`: read port 1 data, combinational.
REQ-009 SHALL declare `rs2_data  output  32`: read port 2 data, combinational.
REQ-010 SHALL declare `ready  output  1`: high once the register array is initialised.

Function
REQ-011 SHALL hold 32 registers x0..x31, each 32 bits.
REQ-012 SHALL implement a two-state FSM:
- CLEAR: sweeps the 5-bit counter clr_idx from 0 to 31, writing 0 into entry clr_idx each cycle.
- READY: normal operation.
REQ-013 SHALL transition CLEAR->READY on the edge that clears entry 31; READY has no exit except rst.
REQ-014 SHALL drive ready=0 in CLEAR and ready=1 in READY.
- ready SHALL first read 1 after the 32nd rising edge with rst=0.
REQ-015 SHALL, in READY, write rd_data into entry rd_addr on the rising edge when reg_write_en=1 and rd_addr!=0.
REQ-016 SHALL ignore writes to rd_addr=0; rs1_data/rs2_data SHALL be 0 whenever the corresponding address is 0.
REQ-017 SHALL, in CLEAR, ignore reg_write_en entirely and drive rs1_data=rs2_data=0.
REQ-018 SHALL, in READY, give zero-latency reads: rsN_data = entry[rsN_addr] combinationally.
REQ-019 SHALL let both read ports address the same register simultaneously and return identical data.
REQ-020 SHALL, when a same-cycle write and read target the same address, return the pre-write value unless REQ-028 applies.
REQ-021 SHALL restrict arithmetic to the clr_idx increment, 5 bits; the write at clr_idx=31 terminates the sweep rather than wrapping.

Reset
REQ-022 SHALL, on any rising edge with rst=1: state=CLEAR, clr_idx=0, ready=0, no array write.
REQ-023 SHALL, when rst asserts mid-CLEAR, restart the sweep at index 0.
REQ-024 SHALL, when rst asserts in READY, abandon any pending write and re-enter CLEAR.
REQ-025 SHALL hold rs1_data=rs2_data=0 while rst=1.

Configuration
REQ-026 SHALL gate write-to-read bypass with macro REGFILE_BYPASS_EN.
REQ-027 SHALL, without REGFILE_BYPASS_EN, behave per REQ-020 (read-old).
REQ-028 SHALL, with REGFILE_BYPASS_EN, forward rd_data to a read port when all of the following hold:
- state READY
- reg_write_en=1
- rd_addr!=0
- rd_addr equals that port's address
REQ-029 SHALL keep all other behaviour identical in both builds.

Structure
REQ-030 SHALL place XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the FSM state typedef (CLEAR, READY) in shared package riscv_pkg.
REQ-031 SHALL implement the sweep counter and FSM in sub-module regfile_init_ctrl (outputs: clr_idx, clr_we, ready); the array stays in regfile.

Verification
REQ-032 SHALL cover reset/clear: deassert rst, count edges.
- ready=0 through edge 31 and 1 after edge 32.
- Writes attempted during CLEAR have no effect; all 32 regs then read 0.
REQ-033 SHALL cover basic write/read: in READY, write x5=0xDEADBEEF.
- Next cycle, rs1_addr=5 and rs2_addr=5 both read 0xDEADBEEF.
REQ-034 SHALL cover x0: write x0=0xFFFFFFFF, then read rs1_addr=0 -> 0x00000000.
REQ-035 SHALL cover same-cycle hazard: x7=0x11 is stored; write x7=0x22 while rs2_addr=7.
- Without REGFILE_BYPASS_EN: 0x11 that cycle, 0x22 the next.
- With REGFILE_BYPASS_EN: 0x22 in the same cycle.
REQ-036 SHALL cover mid-clear reset: assert rst at sweep index 10.
- ready stays 0 for a full 32 edges after deassert.
REQ-037 SHALL cover reset in READY: with x3=0x1234, pulse rst for one edge.
- ready=0 for 32 edges, then x3 reads 0.
